// File: rtl/router_fsm.sv
// Router control FSM: header decode, payload/parity load sequencing,
// full-FIFO stall handling and per-port timeout soft reset of idle FIFOs.
module router_fsm #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] dest,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_en,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       write_enb_reg,
  output logic [2:0] write_en,
  output logic [2:0] soft_rst
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    WAIT_TILL_EMPTY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       dest_q, dest_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [2:0]       soft_rst_q;

  // State and latched destination register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DECODE_ADDRESS;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  // Per-port timeout counters; a pulse is issued on the TIMEOUT-th stale cycle
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 3; k++) begin
      if (rst) begin
        cnt_q[k]      <= '0;
        soft_rst_q[k] <= 1'b0;
      end else if (fifo_empty[k] || read_en[k]) begin
        cnt_q[k]      <= '0;
        soft_rst_q[k] <= 1'b0;
      end else if (cnt_q[k] == CNT_W'(TIMEOUT - 1)) begin
        cnt_q[k]      <= '0;
        soft_rst_q[k] <= 1'b1;
      end else begin
        cnt_q[k]      <= cnt_q[k] + 1'b1;
        soft_rst_q[k] <= 1'b0;
      end
    end
  end

  // Next-state logic; a soft reset on the active port aborts the packet
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && dest != 2'd3) begin
          dest_d  = dest;
          state_d = fifo_empty[dest] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full[dest_q])  state_d = FIFO_FULL_STATE;
        else if (!pkt_valid)    state_d = LOAD_PARITY;
      end
      WAIT_TILL_EMPTY: begin
        if (fifo_empty[dest_q]) state_d = LOAD_FIRST_DATA;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full[dest_q]) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full[dest_q] ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    if (state_q != DECODE_ADDRESS && soft_rst_q[dest_q]) begin
      state_d = DECODE_ADDRESS;
    end
  end

  // Moore output decodes
  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    full_state    = (state_q == FIFO_FULL_STATE);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_FIRST_DATA) || (state_q == LOAD_DATA) ||
                    (state_q == LOAD_AFTER_FULL) || (state_q == LOAD_PARITY);
    busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
    write_en      = write_enb_reg ? (3'b001 << dest_q) : 3'b000;
    soft_rst      = soft_rst_q;
  end

endmodule

// File: tb/tb_router_fsm.sv
// Randomized bench for router_fsm against a behavioural packet-flow model.
module tb_router_fsm;

  localparam int TO = 30;

  logic       clk = 1'b0;
  logic       rst, pkt_valid, parity_done, low_pkt_valid;
  logic [1:0] dest;
  logic [2:0] fifo_full, fifo_empty, read_en;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, busy, write_enb_reg;
  logic [2:0] write_en, soft_rst;

  int tests = 0;
  int fails = 0;

  router_fsm #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .dest(dest),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_en(read_en),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .busy(busy), .write_enb_reg(write_enb_reg), .write_en(write_en),
    .soft_rst(soft_rst)
  );

  always #5 clk = ~clk;

  // Reference model: phase of the packet, latched port, stale-cycle counts
  typedef enum int {P_IDLE, P_FIRST, P_BODY, P_WAIT, P_STALL, P_RESUME, P_PAR, P_CHK} phase_t;
  phase_t ph = P_IDLE;
  int     mdest = 0;
  int     stale [3] = '{0, 0, 0};
  bit     pulse [3] = '{0, 0, 0};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    phase_t n;
    if (rst) begin
      ph = P_IDLE; mdest = 0;
      for (int k = 0; k < 3; k++) begin stale[k] = 0; pulse[k] = 0; end
      return;
    end
    n = ph;
    case (ph)
      P_IDLE:   if (pkt_valid && dest < 3) begin
                  mdest = dest;
                  n = fifo_empty[dest] ? P_FIRST : P_WAIT;
                end
      P_FIRST:  n = P_BODY;
      P_BODY:   n = fifo_full[mdest] ? P_STALL : (pkt_valid ? P_BODY : P_PAR);
      P_WAIT:   n = fifo_empty[mdest] ? P_FIRST : P_WAIT;
      P_STALL:  n = fifo_full[mdest] ? P_STALL : P_RESUME;
      P_RESUME: n = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
      P_PAR:    n = P_CHK;
      P_CHK:    n = fifo_full[mdest] ? P_STALL : P_IDLE;
      default:  n = P_IDLE;
    endcase
    if (ph != P_IDLE && pulse[mdest]) n = P_IDLE;
    ph = n;
    for (int k = 0; k < 3; k++) begin
      pulse[k] = 0;
      if (fifo_empty[k] || read_en[k]) stale[k] = 0;
      else begin
        stale[k]++;
        if (stale[k] == TO) begin pulse[k] = 1; stale[k] = 0; end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] exp_dec, got_dec;
    logic [2:0] exp_we, exp_sr;
    bit load;
    load = (ph == P_FIRST) || (ph == P_BODY) || (ph == P_RESUME) || (ph == P_PAR);
    exp_dec = {ph == P_IDLE, ph == P_FIRST, ph == P_BODY, ph == P_RESUME,
               ph == P_STALL, ph == P_CHK, !(ph == P_IDLE || ph == P_BODY), load};
    got_dec = {detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, busy, write_enb_reg};
    exp_we  = 3'b000;
    if (load) exp_we[mdest] = 1'b1;
    exp_sr  = {pulse[2], pulse[1], pulse[0]};
    chk("decodes", got_dec, exp_dec);
    chk("write_en", {5'b0, write_en}, {5'b0, exp_we});
    chk("soft_rst", {5'b0, soft_rst}, {5'b0, exp_sr});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic quiet(input logic [2:0] empty);
    rst = 0; pkt_valid = 0; dest = 0; fifo_full = 0; fifo_empty = empty;
    read_en = 0; parity_done = 0; low_pkt_valid = 0;
  endtask

  initial begin
    bit stall [3];
    quiet(3'b111);
    rst = 1;
    tick();
    chk("reset_detect", {7'b0, detect_add}, 8'd1);
    chk("reset_we", {5'b0, write_en}, 8'd0);

    // Empty-FIFO packet to port 1
    quiet(3'b111); pkt_valid = 1; dest = 2'd1;
    tick();
    chk("lfd_we", {4'b0, lfd_state, write_en}, 8'b0000_1010);
    tick(); pkt_valid = 0; tick(); tick(); tick();
    chk("pkt_done", {7'b0, detect_add}, 8'd1);

    // Timeout on port 1: pulse on the 30th stale cycle
    quiet(3'b101);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_early", {5'b0, soft_rst}, 8'd0);
    tick();
    chk("to_pulse", {5'b0, soft_rst}, 8'b010);
    tick();
    chk("to_once", {5'b0, soft_rst}, 8'd0);

    // Read at cycle 29 suppresses the pulse
    rst = 1; tick(); quiet(3'b101);
    for (int i = 0; i < TO - 2; i++) tick();
    read_en = 3'b010; tick(); read_en = 0; tick();
    chk("to_read", {5'b0, soft_rst}, 8'd0);

    // Abort from WAIT_TILL_EMPTY on port 2 timeout; invalid dest stays idle
    rst = 1; tick(); quiet(3'b011); pkt_valid = 1; dest = 2'd2;
    tick(); pkt_valid = 0;
    chk("wait_busy", {6'b0, busy, write_enb_reg}, 8'b10);
    for (int i = 0; i < TO; i++) tick();
    chk("abort", {7'b0, detect_add}, 8'd1);
    quiet(3'b111); pkt_valid = 1; dest = 2'd3; tick();
    chk("bad_dest", {7'b0, detect_add}, 8'd1);

    // Randomized traffic
    quiet(3'b111);
    for (int k = 0; k < 3; k++) stall[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      dest          = 2'($urandom_range(0, 3));
      fifo_full     = 3'($urandom) & 3'($urandom);
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 1) == 0);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 39) == 0) stall[k] = ($urandom_range(0, 1) == 0);
        fifo_empty[k] = stall[k] ? 1'b0 : 1'($urandom);
        read_en[k]    = stall[k] ? 1'b0 : ($urandom_range(0, 3) == 0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 Parameter TIMEOUT, default 30, is the number of consecutive cycles a non-empty, unread output FIFO is tolerated before it is soft-reset.
REQ-002 Parameter CNT_W, default 5, is the width of each timeout counter and SHALL satisfy 2**CNT_W > TIMEOUT.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port pkt_valid, input, 1: source is driving header/payload bytes.
REQ-006 Port dest, input, 2: header address bits (data byte [1:0]); 0..2 valid, 3 invalid.
REQ-007 Port fifo_full, input, 3: full flag per output FIFO.
REQ-008 Port fifo_empty, input, 3: empty flag per output FIFO.
REQ-009 Port read_en, input, 3: per-port read strobe from the destination.
REQ-010 Port parity_done, input, 1: parity byte has been written.
REQ-011 Port low_pkt_valid, input, 1: pkt_valid fell while the FSM was stalled in FIFO_FULL_STATE.
REQ-012 Ports detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy, write_enb_reg: outputs, 1 bit each, state decodes per REQ-024.
REQ-013 Port write_en, output, 3: one-hot FIFO write enable.
REQ-014 Port soft_rst, output, 3: per-port soft reset to the output FIFOs.

Function
REQ-015 The FSM SHALL have eight states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR.
REQ-016 In DECODE_ADDRESS, with pkt_valid=1 and dest=k (k<=2), the block SHALL latch dest into dest_q and go to LOAD_FIRST_DATA if fifo_empty[k]=1, else to WAIT_TILL_EMPTY; with dest=3 or pkt_valid=0 it SHALL stay.
REQ-017 LOAD_FIRST_DATA SHALL go to LOAD_DATA after exactly one cycle.
REQ-018 LOAD_DATA SHALL go to FIFO_FULL_STATE if fifo_full[dest_q]=1, else to LOAD_PARITY if pkt_valid=0, else stay; full takes priority.
REQ-019 FIFO_FULL_STATE SHALL stay while fifo_full[dest_q]=1, else go to LOAD_AFTER_FULL.
REQ-020 LOAD_AFTER_FULL SHALL go to DECODE_ADDRESS if parity_done=1; else to LOAD_PARITY if low_pkt_valid=1; else to LOAD_DATA.
REQ-021 LOAD_PARITY SHALL go to CHECK_PARITY_ERROR after one cycle.
REQ-022 CHECK_PARITY_ERROR SHALL go to FIFO_FULL_STATE if fifo_full[dest_q]=1, else to DECODE_ADDRESS.
REQ-023 WAIT_TILL_EMPTY SHALL go to LOAD_FIRST_DATA when fifo_empty[dest_q]=1, else stay.
REQ-024 Decodes SHALL be Moore outputs of the current state: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; full_state=FIFO_FULL_STATE; laf_state=LOAD_AFTER_FULL; rst_int_reg=CHECK_PARITY_ERROR; write_enb_reg in LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY; busy in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-025 write_en SHALL equal the one-hot of dest_q when write_enb_reg=1, else 3'b000.
REQ-026 For each port k, counter cnt[k] SHALL clear when fifo_empty[k]=1 or read_en[k]=1, and otherwise increment.
REQ-027 When cnt[k] reaches TIMEOUT-1 and the increment condition holds, soft_rst[k] SHALL be registered high for exactly one cycle and cnt[k] SHALL clear.
REQ-028 If soft_rst[dest_q]=1 in any state other than DECODE_ADDRESS, the next state SHALL be DECODE_ADDRESS, overriding REQ-016..REQ-023.
REQ-029 A soft_rst on a port other than dest_q SHALL NOT affect the FSM.
REQ-030 dest_q SHALL change only on the DECODE_ADDRESS exit of REQ-016.

Reset
REQ-031 With rst=1 at a clock edge, the state SHALL become DECODE_ADDRESS, dest_q=0, all cnt=0, and soft_rst=3'b000; one cycle later detect_add=1, every other decode output=0, and write_en=3'b000.
REQ-032 rst SHALL take priority over every transition, counter update and soft reset, including mid-packet.

Verification
REQ-033 Directed case -- empty FIFO: dest=1, pkt_valid=1, fifo_empty=3'b111 -> LOAD_FIRST_DATA with write_en=3'b010 and lfd_state=1 next cycle, then LOAD_DATA; pkt_valid=0 -> LOAD_PARITY -> CHECK_PARITY_ERROR -> DECODE_ADDRESS.
REQ-034 Directed case -- busy FIFO: dest=2, fifo_empty[2]=0 -> WAIT_TILL_EMPTY with busy=1 and write_en=0; raising fifo_empty[2] -> LOAD_FIRST_DATA.
REQ-035 Directed case -- full stall: fifo_full[0]=1 in LOAD_DATA -> FIFO_FULL_STATE with write_en=0; on release with low_pkt_valid=1 -> LOAD_AFTER_FULL -> LOAD_PARITY.
REQ-036 Directed case -- timeout: fifo_empty[1]=0 and read_en[1]=0 for 30 cycles -> soft_rst[1] pulses once on the 30th cycle; a read_en pulse at cycle 29 -> no pulse.
REQ-037 Directed case -- abort: soft_rst on dest_q while in WAIT_TILL_EMPTY -> DECODE_ADDRESS next cycle; dest=3 with pkt_valid=1 -> remains in DECODE_ADDRESS.
REQ-038 Directed case -- mid-packet reset: rst=1 in FIFO_FULL_STATE -> detect_add=1 and all counters 0 on the next cycle.
